// File: rtl/scroll_msg_buffer_if.sv
// ----------------------------------------------------------------------------
// scroll_msg_buffer_if
//   Character write port of the scrolling message buffer.
//   master : drives wr_valid / wr_char / wr_last, samples wr_ready
//   slave  : the buffer; samples the request, drives wr_ready
//   A character is transferred on every cycle with wr_valid && wr_ready.
// ----------------------------------------------------------------------------
interface scroll_msg_buffer_if;
    logic       wr_valid;   // character write request
    logic [3:0] wr_char;    // character code
    logic       wr_last;    // this character ends the message
    logic       wr_ready;   // buffer accepts a write this cycle

    modport master (output wr_valid, output wr_char, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_char, input wr_last, output wr_ready);
endinterface

// File: rtl/scroll_msg_buffer.sv
// ----------------------------------------------------------------------------
// scroll_msg_buffer
//   Message source for the four-digit LED mux/decoder chain. Stores up to
//   MSG_LEN 4-bit character codes and shows a registered 4-character window
//   that advances one position every TICK_DIV cycles while run_i is high.
//   A new message is loaded through the write port; committing it restarts
//   scrolling from its first character.
//
// Ports
//   clk_i   : clock, all state on the rising edge
//   rst_i   : asynchronous active-high reset
//   wr      : character write port (slave side of scroll_msg_buffer_if)
//   dir_i   : scroll direction, 1 = backwards (only with SCROLL_REVERSE_EN)
//   run_i   : 1 = scrolling enabled, 0 = paused (divider and head hold)
//   disp_o  : {digit3,digit2,digit1,digit0}, digit3 leftmost
//   step_o  : one-cycle pulse on every window advance
//
// Build option
//   SCROLL_REVERSE_EN : adds dir_i and reverse scrolling; undefined builds
//                       scroll forward only.
// ----------------------------------------------------------------------------
module scroll_msg_buffer #(
    parameter int MSG_LEN  = 16,          // power of 2, 4..16
    parameter int TICK_DIV = 50_000_000,  // cycles per scroll step, >= 2
    parameter int CNT_W    = 26           // 2**CNT_W >= TICK_DIV
) (
    input  logic               clk_i,
    input  logic               rst_i,
    scroll_msg_buffer_if.slave wr,
`ifdef SCROLL_REVERSE_EN
    input  logic               dir_i,
`endif
    input  logic               run_i,
    output logic [15:0]        disp_o,
    output logic               step_o
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int PW = AW + 1;           // holds 0..MSG_LEN

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       mem_q [MSG_LEN];
    logic [PW-1:0]    len_q, len_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             step_q, step_d;
    logic [15:0]      disp_q, disp_d;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [PW-1:0]    head_adv;
    logic [15:0]      window;
    logic             wr_fire, wr_final;

    // wr_ready is a pure function of state, so the fire term uses state directly
    assign wr_fire  = wr.wr_valid && (state_q != S_COMMIT);
    // The write into the last slot closes the message even without wr_last
    assign wr_final = wr_fire && (wr.wr_last ||
                      (state_q == S_LOAD && wr_ptr_q == PW'(MSG_LEN - 1)));

    // Window: indices wrap modulo len, so short messages repeat in the window
    always_comb begin
        window = '0;
        for (int k = 0; k < 4; k++)
            window[15-4*k -: 4] = mem_q[AW'((head_q + PW'(k)) % len_q)];
    end

    // Next head position for a scroll tick
    always_comb begin
        head_adv = (head_q == len_q - PW'(1)) ? '0 : head_q + PW'(1);
`ifdef SCROLL_REVERSE_EN
        if (dir_i)
            head_adv = (head_q == '0) ? len_q - PW'(1) : head_q - PW'(1);
`endif
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (wr_fire) state_d = wr_final ? S_COMMIT : S_LOAD;
            S_LOAD:   if (wr_final) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wr.wr_ready = 1'b1;
        if (state_q == S_COMMIT) wr.wr_ready = 1'b0;
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        len_d     = len_q;
        head_d    = head_q;
        wr_ptr_d  = wr_ptr_q;
        div_cnt_d = div_cnt_q;
        step_d    = 1'b0;
        disp_d    = disp_q;       // frozen while a message is being loaded
        mem_we    = 1'b0;
        mem_waddr = '0;
        case (state_q)
            S_IDLE: begin
                disp_d = window;
                if (wr_fire) begin
                    // A write wins over a same-cycle tick
                    mem_we    = 1'b1;
                    wr_ptr_d  = PW'(1);
                    div_cnt_d = '0;
                end else if (run_i) begin
                    if (div_cnt_q == CNT_W'(TICK_DIV - 1)) begin
                        div_cnt_d = '0;
                        step_d    = 1'b1;
                        head_d    = head_adv;
                    end else begin
                        div_cnt_d = div_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD: begin
                if (wr_fire) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_q[AW-1:0];
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                end
            end
            S_COMMIT: begin
                len_d    = wr_ptr_q;      // number of characters written
                head_d   = '0;
                wr_ptr_d = '0;
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= 4'(i);
            len_q     <= PW'(MSG_LEN);
            head_q    <= '0;
            wr_ptr_q  <= '0;
            div_cnt_q <= '0;
            step_q    <= 1'b0;
            disp_q    <= 16'h0123;   // window of the reset contents
        end else begin
            if (mem_we) mem_q[mem_waddr] <= wr.wr_char;
            len_q     <= len_d;
            head_q    <= head_d;
            wr_ptr_q  <= wr_ptr_d;
            div_cnt_q <= div_cnt_d;
            step_q    <= step_d;
            disp_q    <= disp_d;
        end
    end

    assign disp_o = disp_q;
    assign step_o = step_q;
endmodule

// File: tb/tb_scroll_msg_buffer.sv
// ----------------------------------------------------------------------------
// tb_scroll_msg_buffer
//   Directed scenarios followed by a randomized phase. A message-level
//   reference model (character array, length, head, tick counter) predicts
//   disp/step/wr_ready every cycle; directed points also compare against
//   fixed expected windows.
// ----------------------------------------------------------------------------
module tb_scroll_msg_buffer;
    localparam int MSG_LEN  = 16;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] disp;
    logic        step;

    scroll_msg_buffer_if wif();

    scroll_msg_buffer #(.MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .wr     (wif),
`ifdef SCROLL_REVERSE_EN
        .dir_i  (dir),
`endif
        .run_i  (run),
        .disp_o (disp),
        .step_o (step)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    logic [3:0]  m_mem [MSG_LEN];
    int          m_len, m_head, m_cnt, m_wptr;
    bit          m_loading, m_commit, m_step;
    logic [15:0] m_disp;

    task automatic m_reset();
        for (int i = 0; i < MSG_LEN; i++) m_mem[i] = 4'(i);
        m_len = MSG_LEN; m_head = 0; m_cnt = 0; m_wptr = 0;
        m_loading = 0; m_commit = 0; m_step = 0;
        m_disp = 16'h0123;
    endtask

    function automatic logic [15:0] m_window();
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[15-4*k -: 4] = m_mem[(m_head + k) % m_len];
        return w;
    endfunction

    // Effect of one clock edge with the given inputs applied
    task automatic m_adv(input bit v, input logic [3:0] c, input bit l, input bit r);
        logic [15:0] nd;
        nd = (m_loading || m_commit) ? m_disp : m_window();
        m_step = 0;
        if (m_commit) begin
            m_len = m_wptr; m_head = 0; m_wptr = 0; m_commit = 0;
        end else if (m_loading) begin
            if (v) begin
                m_mem[m_wptr] = c;
                m_wptr++;
                if (l || m_wptr == MSG_LEN) begin m_loading = 0; m_commit = 1; end
            end
        end else if (v) begin
            m_mem[0] = c; m_wptr = 1; m_cnt = 0;
            if (l) m_commit = 1; else m_loading = 1;
        end else if (r) begin
            m_cnt++;
            if (m_cnt == TICK_DIV) begin
                m_cnt = 0; m_step = 1;
                m_head = dir ? (m_head + m_len - 1) % m_len : (m_head + 1) % m_len;
            end
        end
        m_disp = nd;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [3:0] c, input bit l, input bit r);
        wif.wr_valid = v; wif.wr_char = c; wif.wr_last = l; run = r;
        m_adv(v, c, l, r);
        @(posedge clk); #1;
        chk("disp", 32'(disp), 32'(m_disp));
        chk("step", 32'(step), 32'(m_step));
        chk("wr_ready", 32'(wif.wr_ready), 32'(!m_commit));
    endtask

    task automatic cyc0(input bit r);
        cyc(1'b0, 4'($urandom), 1'($urandom), r);
    endtask

    task automatic do_reset();
        wif.wr_valid = 0; run = 0;
        #2 rst = 1;
        #1;
        chk("rst_disp", 32'(disp), 32'h0123);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_ready", 32'(wif.wr_ready), 32'h1);
        m_reset();
        @(negedge clk) rst = 0;
        cyc0(1'b0);
    endtask

    task automatic wait_step(input bit r, input int maxc, input string tag);
        int  k;
        bit  seen;
        k = 0; seen = 0;
        while (!seen && k < maxc) begin
            cyc0(r);
            seen = step;
            k++;
        end
        chk(tag, 32'(seen), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_steps;
        int paused_steps;
        wif.wr_valid = 0; wif.wr_char = 0; wif.wr_last = 0;
        m_reset();
        do_reset();

        // Free-running scroll from reset contents
        repeat (3) cyc0(1'b1);
        cyc0(1'b1);
        chk("first_step", 32'(step), 32'h1);
        cyc0(1'b1);
        chk("win_1234", 32'(disp), 32'h1234);
        n_steps = 1;
        repeat (48) begin cyc0(1'b1); if (step) n_steps++; end
        chk("step_cnt", 32'(n_steps), 32'd13);
        chk("win_DEF0", 32'(disp), 32'hDEF0);

        // Three-character message
        cyc(1'b1, 4'hA, 1'b0, 1'b1);
        cyc(1'b1, 4'hB, 1'b0, 1'b1);
        cyc(1'b1, 4'hC, 1'b1, 1'b1);
        chk("commit_ready", 32'(wif.wr_ready), 32'h0);
        cyc0(1'b1);
        chk("ready_back", 32'(wif.wr_ready), 32'h1);
        cyc0(1'b1);
        chk("win_ABCA", 32'(disp), 32'hABCA);
        wait_step(1'b1, 8, "step_abc");
        cyc0(1'b1);
        chk("win_BCAB", 32'(disp), 32'hBCAB);

        // Full-length message forces commit; next write starts a new one
        for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 1'b0, 1'b1);
        chk("force_commit", 32'(wif.wr_ready), 32'h0);
        cyc(1'b1, 4'h5, 1'b1, 1'b1);   // offered during commit, not taken
        cyc(1'b1, 4'h5, 1'b1, 1'b1);
        cyc0(1'b1);
        cyc0(1'b1);
        chk("win_5555", 32'(disp), 32'h5555);

        // Pause with divider at 2, then resume
        wait_step(1'b1, 8, "sync_step");
        cyc0(1'b1);
        cyc0(1'b1);
        paused_steps = 0;
        repeat (10) begin cyc0(1'b0); if (step) paused_steps++; end
        chk("pause_nostep", 32'(paused_steps), 32'h0);
        cyc0(1'b1);
        chk("resume_1", 32'(step), 32'h0);
        cyc0(1'b1);
        chk("resume_2", 32'(step), 32'h1);

        // Write on the tick cycle suppresses the step
        repeat (3) cyc0(1'b1);
        cyc(1'b1, 4'h7, 1'b1, 1'b1);
        chk("tick_suppressed", 32'(step), 32'h0);
        cyc0(1'b1);
        cyc0(1'b1);
        chk("win_7777", 32'(disp), 32'h7777);

        // Reset in the middle of loading
        cyc(1'b1, 4'h9, 1'b0, 1'b1);
        cyc(1'b1, 4'h8, 1'b0, 1'b1);
        do_reset();
        cyc(1'b1, 4'hA, 1'b1, 1'b0);
        cyc0(1'b0);
        cyc0(1'b0);
        chk("win_AAAA", 32'(disp), 32'hAAAA);

        // Randomized traffic against the model
        repeat (400) begin
            bit v, l, r;
            v = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) != 0);
`ifdef SCROLL_REVERSE_EN
            dir = 1'($urandom);
`endif
            cyc(v, 4'($urandom), l, r);
        end

`ifdef SCROLL_REVERSE_EN
        dir = 1'b0;
        do_reset();
        dir = 1'b1;
        wait_step(1'b1, 8, "rev_step");
        cyc0(1'b1);
        chk("win_F012", 32'(disp), 32'hF012);
        dir = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
